// File: rtl/dds_sweep_if.sv
// Configuration/handshake bundle between the command controller and the DDS sweep sequencer.
// The master drives the sweep configuration; the slave (sequencer) returns the phase increment and status.
interface dds_sweep_if #(
  parameter int unsigned DWELL_W = 24
) ();
  logic               start;
  logic               abort;
  logic               cont;
  logic [31:0]        f_start;
  logic [31:0]        f_stop;
  logic [31:0]        f_step;
  logic [DWELL_W-1:0] dwell;
  logic [31:0]        adder;
  logic               upd;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, cont, f_start, f_stop, f_step, dwell,
    input  adder, upd, busy, done
  );

  modport slave (
    input  start, abort, cont, f_start, f_stop, f_step, dwell,
    output adder, upd, busy, done
  );
endinterface

// File: rtl/dds_sweep.sv
// Linear frequency-sweep sequencer feeding the DDS phase-increment register.
// Steps adder from f_start to f_stop by f_step, holding each value dwell+1 clocks, single or continuous.
module dds_sweep #(
  parameter logic [31:0] ADDER_RST = 32'd1073741,
  parameter int unsigned DWELL_W   = 24
) (
  input  logic       clk,
  input  logic       rst,
  dds_sweep_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        adder_q, adder_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               upd_q, upd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               capture;

  logic [31:0]        start_s_q, start_s_d;
  logic [31:0]        stop_s_q, stop_s_d;
  logic [31:0]        step_s_q, step_s_d;
  logic [DWELL_W-1:0] dwell_s_q, dwell_s_d;
  logic               cont_s_q, cont_s_d;
  logic               up_s_q, up_s_d;

  // Next value, saturated at stop: any carry/borrow out of 32 bits, or landing on/past stop, clamps.
  function automatic logic [31:0] step_next(input logic [31:0] cur,
                                            input logic [31:0] step,
                                            input logic [31:0] stop,
                                            input logic        up);
    logic [32:0] nxt;
    nxt = 33'd0;
    if (step == 32'd0) begin
      return stop;
    end
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, step};
      if (nxt[32] || (nxt[31:0] >= stop)) begin
        return stop;
      end
    end else begin
      nxt = {1'b0, cur} - {1'b0, step};
      if (nxt[32] || (nxt[31:0] <= stop)) begin
        return stop;
      end
    end
    return nxt[31:0];
  endfunction

  always_comb begin
    state_d = state_q;
    adder_d = adder_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          capture = 1'b1;
          adder_d = bus.f_start;
          upd_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = bus.dwell;
          state_d = DWELL;
        end
      end

      DWELL: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (adder_q != stop_s_q) begin
          adder_d = step_next(adder_q, step_s_q, stop_s_q, up_s_q);
          upd_d   = 1'b1;
          cnt_d   = dwell_s_q;
        end else if (cont_s_q) begin
          // Wrap back to the first value with the normal step spacing.
          adder_d = start_s_q;
          upd_d   = 1'b1;
          cnt_d   = dwell_s_q;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Shadow copies of the configuration, frozen for the duration of a sweep.
  always_comb begin
    start_s_d = start_s_q;
    stop_s_d  = stop_s_q;
    step_s_d  = step_s_q;
    dwell_s_d = dwell_s_q;
    cont_s_d  = cont_s_q;
    up_s_d    = up_s_q;
    if (capture) begin
      start_s_d = bus.f_start;
      stop_s_d  = bus.f_stop;
      step_s_d  = bus.f_step;
      dwell_s_d = bus.dwell;
      cont_s_d  = bus.cont;
      up_s_d    = (bus.f_stop >= bus.f_start);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      adder_q <= ADDER_RST;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adder_q <= adder_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Configuration is only read after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    start_s_q <= start_s_d;
    stop_s_q  <= stop_s_d;
    step_s_q  <= step_s_d;
    dwell_s_q <= dwell_s_d;
    cont_s_q  <= cont_s_d;
    up_s_q    <= up_s_d;
  end

  assign bus.adder = adder_q;
  assign bus.upd   = upd_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/dds_sweep.md
# dds_sweep

Frequency-sweep sequencer for the DDS phase accumulator. It takes a start/stop/step/dwell configuration and drives the 32-bit phase-increment (`adder`) seen by the DDS core. It steps that increment linearly from start to stop, holding each value for a programmable number of clocks, in single-shot or continuous mode. It sits between the UART command controller, which supplies the configuration, and the DDS adder input.

## Interface
- `ADDER_RST`, 32'd1073741, `adder` value after reset (codebase DDS default)
- `DWELL_W`, 24, width of dwell counter/config
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  start sweep; sampled only in IDLE
- `abort`  in  1  stop sweep immediately; any state
- `cont`  in  1  0 = single sweep, 1 = repeat until abort; latched at start
- `f_start`  in  32  first phase increment
- `f_stop`  in  32  last phase increment
- `f_step`  in  32  increment magnitude per step
- `dwell`  in  DWELL_W  hold time per value, in clocks minus 1
- `adder`  out  32  phase increment to DDS
- `upd`  out  1  1-cycle pulse, coincident with every new `adder` value
- `busy`  out  1  high while sweeping
- `done`  out  1  1-cycle pulse when a single sweep completes

## Operation
- States: IDLE, DWELL.
- On `start=1` in IDLE, with `abort=0`:
  - latch `f_start`, `f_stop`, `f_step`, `dwell`, `cont` into shadow registers;
  - `adder <= f_start`, `upd <= 1`, `busy <= 1`, `cnt <= dwell`, go to DWELL.
  - Input changes while busy are ignored.
- Direction: up if `f_stop >= f_start` (unsigned), else down. Fixed per sweep.
- In DWELL with `cnt != 0`: `cnt <= cnt - 1`.
- In DWELL with `cnt == 0`, the current value has expired:
  - **Not final:** compute next = `adder ± f_step` in 33 bits. If next passes or equals `f_stop` (including carry/borrow out of 32 bits), next = `f_stop`. Then `adder <= next`, `upd <= 1`, `cnt <= dwell`.
  - **Final** (`adder == f_stop`), single mode: go to IDLE, `busy <= 0`, `done <= 1`. `adder` holds `f_stop`.
  - **Final**, continuous mode: `adder <= f_start`, `upd <= 1`, `cnt <= dwell`. No `done`.
- `f_step == 0` is treated as a direct step to `f_stop`: the sweep is `f_start`, then `f_stop`.
- `f_start == f_stop`: one value, held dwell+1 clocks, then done (single mode) or repeat (continuous mode).
- `abort=1`: next edge goes to IDLE, `busy <= 0`. `adder` keeps its current value. No `done`, no `upd`. Abort wins over a simultaneous `start`.
- Reset (async, `rst=0`):
  - `adder = ADDER_RST`, `busy = 0`, `done = 0`, `upd = 0`, `cnt = 0`, state IDLE.
  - Takes effect immediately, including mid-sweep.

## Timing
- `start` is sampled at edge T. From T+1: `adder = f_start`, `upd = 1`, `busy = 1`.
- Each value is held exactly dwell+1 clocks. The k-th value (k from 0) appears at T+1+k·(dwell+1).
- Single mode, N values: `done` pulses at T+1+N·(dwell+1), the same cycle `busy` falls.
- A new `start` is accepted in the cycle `done` is high, since the state is already IDLE.
- `upd` and `done` are single-cycle and registered.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Continuous mode: the wrap to `f_start` occurs with the same spacing as any other step, with no idle gap.

## Test plan
- **Up sweep.** Inputs: `f_start=100`, `f_stop=130`, `f_step=10`, `dwell=2`, `cont=0`, start at T.
  - `adder` = 100/110/120/130, appearing at T+1/T+4/T+7/T+10.
  - 4 `upd` pulses.
  - `done` at T+13; `busy` low from T+13.
- **Down sweep with overshoot.** Inputs: `f_start=1000`, `f_stop=975`, `f_step=10`, `dwell=0`.
  - `adder` = 1000, 990, 980, 975, one clock each.
  - `done` at T+5.
- **Overflow clamp.** Inputs: `f_start=32'hFFFF_FFF0`, `f_stop=32'hFFFF_FFFF`, `f_step=32'h20`, `dwell=1`.
  - `adder` = FFFF_FFF0, then FFFF_FFFF; never wraps to a small value.
  - `done` at T+5.
- **Continuous and abort.** Inputs: `f_start=0`, `f_stop=2`, `f_step=1`, `dwell=0`, `cont=1`.
  - `adder` = 0, 1, 2, 0, 1, …; no `done`.
  - Assert `abort` while `adder=1`: `busy=0` next cycle, `adder` stays 1, no `upd`.
  - Same cycle, `start=1` together with `abort=1`: no sweep starts.
- **Reset mid-sweep.** Drop `rst` during DWELL.
  - `adder=1073741`, `busy=0`, `upd=0` immediately, without waiting for a clock edge.
  - After release, a `start` runs a fresh sweep from the newly latched config.
- **Edge configs.** `f_step=0` with `f_start=5`, `f_stop=9`: sequence 5, 9. `f_start=f_stop=7`, `dwell=3`: 7 held 4 clocks, then `done`. Config changes while `busy`: no effect on the sweep.
